// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: mode encoding and
// the rotating-priority scan order used by the arbiter.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Channel examined at scan position k after ptr; k = 0 has highest priority.
  function automatic int unsigned rr_index(int unsigned ptr, int unsigned k, int unsigned n);
    return (ptr + 1 + k) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the channel just after ptr wins,
// wrapping modulo N_IN.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N_IN  = 4,
  localparam int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_IN-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [SEL_W-1:0] scan_idx;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    gnt_idx  = '0;
    scan_idx = '0;
    for (int unsigned j = 0; j < N_IN; j++) begin
      scan_idx = SEL_W'(rr_index(32'(ptr), N_IN - 1 - j, N_IN));
      if (req[scan_idx]) begin
        gnt_idx = scan_idx;
      end
    end
  end

  assign gnt_vld = |req;
  assign gnt     = gnt_vld ? (N_IN'(1) << gnt_idx) : '0;

endmodule

// File: rtl/stream_mux_rr.sv
// N-input stream multiplexer with explicit-select or round-robin arbitration
// feeding a single registered, back-pressurable output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned N_IN  = 4,
  localparam int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_src
);

  logic [SEL_W-1:0] rr_ptr_q;
  logic [N_IN-1:0]  arb_gnt;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_vld;
  logic [SEL_W-1:0] gnt;
  logic             gnt_vld;
  logic             sel_ok;
  logic             load;
  logic             xfer;

  rr_arbiter #(
    .N_IN (N_IN)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // sel can exceed N_IN-1 when N_IN is not a power of two.
  assign sel_ok = (32'(sel) < N_IN);

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    if (mode == MODE_RR) begin
      gnt     = arb_idx;
      gnt_vld = arb_vld;
    end else begin
      gnt     = sel;
      gnt_vld = sel_ok && in_valid[sel];
    end
  end

  assign load = !out_valid || out_ready;
  assign xfer = load && gnt_vld;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready = (mode == MODE_RR) ? arb_gnt : (N_IN'(1) << sel);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr_q  <= SEL_W'(N_IN - 1);
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[32'(gnt) * WIDTH +: WIDTH];
        out_src  <= gnt;
        rr_ptr_q <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 4-channel and a 3-channel instance share stimulus
// and are compared against a queue-free behavioural model of the stream rules.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  in_ready_a;
  logic [7:0]  out_data_a;
  logic        out_valid_a;
  logic [1:0]  out_src_a;
  logic [2:0]  in_ready_b;
  logic [7:0]  out_data_b;
  logic        out_valid_b;
  logic [1:0]  out_src_b;

  int vectors = 0;
  int miscompares = 0;

  // Model state per instance: 0 = four channels, 1 = three channels.
  int          m_n[2] = '{4, 3};
  int          m_ptr[2];
  bit          m_vld[2];
  logic [7:0]  m_data[2];
  int          m_src[2];

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(8), .N_IN(4)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .out_data  (out_data_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_src   (out_src_a)
  );

  stream_mux_rr #(.WIDTH(8), .N_IN(3)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data[23:0]),
    .in_valid  (in_valid[2:0]),
    .in_ready  (in_ready_b),
    .out_data  (out_data_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_src   (out_src_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i]  = m_n[i] - 1;
      m_vld[i]  = 1'b0;
      m_data[i] = 8'h00;
      m_src[i]  = 0;
    end
  endtask

  // Channel that wins this cycle for instance inst, or -1 if none.
  function automatic int pick(input int inst);
    int n;
    n = m_n[inst];
    if (mode == 1'b0) begin
      if (int'(sel) < n && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= n; k++) begin
      if (in_valid[(m_ptr[inst] + k) % n]) return (m_ptr[inst] + k) % n;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    chk("out_valid_a", 32'(out_valid_a), 32'(m_vld[0]));
    chk("out_data_a",  32'(out_data_a),  32'(m_data[0]));
    chk("out_src_a",   32'(out_src_a),   32'(m_src[0]));
    chk("out_valid_b", 32'(out_valid_b), 32'(m_vld[1]));
    chk("out_data_b",  32'(out_data_b),  32'(m_data[1]));
    chk("out_src_b",   32'(out_src_b),   32'(m_src[1]));
  endtask

  // Entered on a falling edge; leaves on the next falling edge.
  task automatic step(input bit md, input logic [1:0] s, input logic [3:0] v,
                      input logic [31:0] d, input bit rdy);
    int   g[2];
    bit   ld[2];
    logic [31:0] er;
    mode = md; sel = s; in_valid = v; in_data = d; out_ready = rdy;
    #1;
    check_outputs();
    for (int i = 0; i < 2; i++) begin
      ld[i] = !m_vld[i] || rdy;
      g[i]  = ld[i] ? pick(i) : -1;
    end
    er = (g[0] >= 0) ? (32'd1 << g[0]) : 32'd0;
    chk("in_ready_a", 32'(in_ready_a), er);
    er = (g[1] >= 0) ? (32'd1 << g[1]) : 32'd0;
    chk("in_ready_b", 32'(in_ready_b), er);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (ld[i]) begin
        m_vld[i] = (g[i] >= 0);
        if (g[i] >= 0) begin
          m_data[i] = d[g[i]*8 +: 8];
          m_src[i]  = g[i];
          m_ptr[i]  = g[i];
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'h0; in_data = 32'h0; out_ready = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness from reset: channel 0 first, then rotation.
    step(1'b1, 2'd0, 4'hF, $urandom, 1'b1);
    chk("rr_first_src", 32'(out_src_a), 32'd0);
    repeat (8) step(1'b1, 2'd0, 4'hF, $urandom, 1'b1);

    // Explicit select of channel 2.
    step(1'b0, 2'd2, 4'hF, 32'h43322110, 1'b1);
    chk("sel_data", 32'(out_data_a), 32'h32);
    chk("sel_src",  32'(out_src_a),  32'd2);

    // Back-pressure holds the output and freezes the pointer.
    repeat (3) step(1'b1, 2'd0, 4'hF, $urandom, 1'b0);
    repeat (2) step(1'b1, 2'd0, 4'hF, $urandom, 1'b1);

    // Sparse requests after pointer lands on 2: expect 0,1,0.
    step(1'b0, 2'd2, 4'hF, $urandom, 1'b1);
    repeat (3) step(1'b1, 2'd0, 4'b0011, $urandom, 1'b1);
    step(1'b1, 2'd0, 4'b0000, $urandom, 1'b1);

    // Selected channel idle: output drains, then accepts as soon as it asks.
    repeat (2) step(1'b0, 2'd1, 4'b1101, $urandom, 1'b1);
    step(1'b0, 2'd1, 4'b0010, $urandom, 1'b1);
    step(1'b0, 2'd1, 4'b0000, $urandom, 1'b1);

    // Select index 3 is out of range for the three-channel instance.
    repeat (2) step(1'b0, 2'd3, 4'hF, $urandom, 1'b1);

    // Asynchronous reset while a word is held.
    step(1'b1, 2'd0, 4'hF, $urandom, 1'b1);
    step(1'b1, 2'd0, 4'hF, $urandom, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'd0, 4'hF, $urandom, 1'b1);
    chk("rr_after_reset_src", 32'(out_src_a), 32'd0);

    repeat (400) begin
      step(1'($urandom), 2'($urandom), 4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
